// File: rtl/orientation_math_param.sv
// Purpose : heading bin of a move between two polar fixes {theta index, radius}.
// Latency : 1 cycle (same-theta shortcut), 3 (no movement), N_BINS+3 (general path).
// Backpres: none; enable is taken only in IDLE, requests while busy are dropped.
//
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   enable                - start request, sampled only in IDLE
//   r_theta_original      - {theta index, radius} of the start position
//   r_theta_final         - {theta index, radius} of the end position
//   busy                  - high from the cycle after capture until done
//   done                  - one-cycle pulse when orientation/no_move are valid
//   no_move               - 1 = movement below MIN_MOVE on both axes
//   orientation           - heading bin, counter-clockwise from +x
module orientation_math_param #(
  parameter int R_W       = 8,
  parameter int T_W       = 4,
  parameter int STEP_DEG  = 15,
  parameter int N_BINS    = 24,
  parameter int ORI_W     = 5,
  parameter int TRIG_FRAC = 8,
  parameter int MIN_MOVE  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [T_W+R_W-1:0] r_theta_original,
  input  logic [T_W+R_W-1:0] r_theta_final,
  output logic               busy,
  output logic               done,
  output logic               no_move,
  output logic [ORI_W-1:0]   orientation
);

  // Trig entries span [-2^TRIG_FRAC, +2^TRIG_FRAC], hence two extra bits.
  localparam int  TRIG_W = TRIG_FRAC + 2;
  // Coordinates and deltas: |r*trig| < 2^(R_W+TRIG_FRAC), the difference of two
  // such values still fits with one guard bit plus sign.
  localparam int  D_W    = R_W + TRIG_FRAC + 2;
  // Dot product: two D_W x TRIG_W products plus one carry bit.
  localparam int  P_W    = D_W + TRIG_W + 1;
  localparam real PI     = 3.14159265358979323846;

  localparam logic signed [D_W-1:0] THR      = D_W'(MIN_MOVE * (2 ** TRIG_FRAC));
  localparam logic [ORI_W-1:0]      LAST_BIN = ORI_W'(N_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_DELTA,
    S_SEARCH,
    S_DONE
  } state_t;

  // Round-to-nearest fixed-point cos/sin of idx*STEP_DEG, evaluated at elaboration.
  function automatic int trig_q(input int idx, input bit is_cos);
    real ang;
    real v;
    ang = real'(idx * STEP_DEG) * PI / 180.0;
    v   = (is_cos ? $cos(ang) : $sin(ang)) * real'(2 ** TRIG_FRAC);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Theta indices may exceed one turn; fold them onto the bin range.
  function automatic logic [ORI_W-1:0] mod_bins(input logic [T_W-1:0] t);
    return ORI_W'(int'(t) % N_BINS);
  endfunction

  function automatic logic [ORI_W-1:0] rev_bin(input logic [ORI_W-1:0] b);
    return ORI_W'((int'(b) + N_BINS / 2) % N_BINS);
  endfunction

  // ------------------------------------------------------------------ ROM
  logic signed [TRIG_W-1:0] w_cos_rom [N_BINS];
  logic signed [TRIG_W-1:0] w_sin_rom [N_BINS];

  for (genvar g = 0; g < N_BINS; g++) begin : g_rom
    localparam int COS_Q = trig_q(g, 1'b1);
    localparam int SIN_Q = trig_q(g, 1'b0);
    assign w_cos_rom[g] = TRIG_W'(COS_Q);
    assign w_sin_rom[g] = TRIG_W'(SIN_Q);
  end

  // ------------------------------------------------------------ registers
  state_t                  r_state;
  logic [T_W+R_W-1:0]      r_word_o;
  logic [T_W+R_W-1:0]      r_word_f;
  logic signed [D_W-1:0]   r_x_o;
  logic signed [D_W-1:0]   r_y_o;
  logic signed [D_W-1:0]   r_x_f;
  logic signed [D_W-1:0]   r_y_f;
  logic signed [D_W-1:0]   r_dx;
  logic signed [D_W-1:0]   r_dy;
  logic [ORI_W-1:0]        r_bin;
  logic signed [P_W-1:0]   r_best_dot;
  logic [ORI_W-1:0]        r_best_idx;

  // ---------------------------------------------------- capture-side decode
  logic [T_W-1:0]   w_in_t_o;
  logic [T_W-1:0]   w_in_t_f;
  logic [R_W-1:0]   w_in_r_o;
  logic [R_W-1:0]   w_in_r_f;
  logic [ORI_W-1:0] w_in_bin;
  logic             w_same_theta;

  assign w_in_t_o     = r_theta_original[T_W+R_W-1 -: T_W];
  assign w_in_t_f     = r_theta_final[T_W+R_W-1 -: T_W];
  assign w_in_r_o     = r_theta_original[R_W-1:0];
  assign w_in_r_f     = r_theta_final[R_W-1:0];
  assign w_in_bin     = mod_bins(w_in_t_o);
  assign w_same_theta = (w_in_t_o == w_in_t_f);

  // ------------------------------------------------------ polar -> cartesian
  logic [ORI_W-1:0]      w_idx_o;
  logic [ORI_W-1:0]      w_idx_f;
  logic signed [D_W-1:0] w_rad_o;
  logic signed [D_W-1:0] w_rad_f;
  logic signed [D_W-1:0] w_x_o;
  logic signed [D_W-1:0] w_y_o;
  logic signed [D_W-1:0] w_x_f;
  logic signed [D_W-1:0] w_y_f;

  assign w_idx_o = mod_bins(r_word_o[T_W+R_W-1 -: T_W]);
  assign w_idx_f = mod_bins(r_word_f[T_W+R_W-1 -: T_W]);
  // Radius is unsigned; zero-extend before the signed multiply.
  assign w_rad_o = D_W'($signed({1'b0, r_word_o[R_W-1:0]}));
  assign w_rad_f = D_W'($signed({1'b0, r_word_f[R_W-1:0]}));
  assign w_x_o   = w_rad_o * D_W'(w_cos_rom[w_idx_o]);
  assign w_y_o   = w_rad_o * D_W'(w_sin_rom[w_idx_o]);
  assign w_x_f   = w_rad_f * D_W'(w_cos_rom[w_idx_f]);
  assign w_y_f   = w_rad_f * D_W'(w_sin_rom[w_idx_f]);

  // ---------------------------------------------------------------- deltas
  logic signed [D_W-1:0] w_dx;
  logic signed [D_W-1:0] w_dy;
  logic                  w_small;

  assign w_dx    = r_x_f - r_x_o;
  assign w_dy    = r_y_f - r_y_o;
  assign w_small = (w_dx < THR) && (w_dx > -THR) && (w_dy < THR) && (w_dy > -THR);

  // ---------------------------------------------------------------- search
  logic signed [P_W-1:0] w_dot;
  logic                  w_take;
  logic [ORI_W-1:0]      w_next_idx;

  assign w_dot      = P_W'(r_dx) * P_W'(w_cos_rom[r_bin]) + P_W'(r_dy) * P_W'(w_sin_rom[r_bin]);
  // Strictly-greater replacement keeps the lowest bin on ties; bin 0 seeds the search.
  assign w_take     = (r_bin == '0) || (w_dot > r_best_dot);
  assign w_next_idx = w_take ? r_bin : r_best_idx;

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_word_o    <= '0;
      r_word_f    <= '0;
      r_x_o       <= '0;
      r_y_o       <= '0;
      r_x_f       <= '0;
      r_y_f       <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_bin       <= '0;
      r_best_dot  <= '0;
      r_best_idx  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      no_move     <= 1'b0;
      orientation <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_word_o <= r_theta_original;
            r_word_f <= r_theta_final;
            if (w_same_theta) begin
              // Radial move along one bearing: outward or inward, no search needed.
              r_state <= S_DONE;
              done    <= 1'b1;
              if (w_in_r_f > w_in_r_o) begin
                orientation <= w_in_bin;
                no_move     <= 1'b0;
              end else if (w_in_r_f < w_in_r_o) begin
                orientation <= rev_bin(w_in_bin);
                no_move     <= 1'b0;
              end else begin
                no_move     <= 1'b1;
              end
            end else begin
              r_state <= S_CONVERT;
              busy    <= 1'b1;
            end
          end
        end

        S_CONVERT: begin
          r_x_o   <= w_x_o;
          r_y_o   <= w_y_o;
          r_x_f   <= w_x_f;
          r_y_f   <= w_y_f;
          r_state <= S_DELTA;
        end

        S_DELTA: begin
          r_dx <= w_dx;
          r_dy <= w_dy;
          if (w_small) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            no_move <= 1'b1;
          end else begin
            r_state <= S_SEARCH;
            r_bin   <= '0;
          end
        end

        S_SEARCH: begin
          if (w_take) begin
            r_best_dot <= w_dot;
            r_best_idx <= r_bin;
          end
          if (r_bin == LAST_BIN) begin
            r_state     <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            no_move     <= 1'b0;
            orientation <= w_next_idx;
          end else begin
            r_bin <= r_bin + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_orientation_math_param.sv
module tb_orientation_math_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] word_o = '0;
  logic [11:0] word_f = '0;
  logic        busy;
  logic        done;
  logic        no_move;
  logic [4:0]  orientation;

  always #5 clock = ~clock;

  orientation_math_param dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .r_theta_original (word_o),
    .r_theta_final    (word_f),
    .busy             (busy),
    .done             (done),
    .no_move          (no_move),
    .orientation      (orientation)
  );

  typedef struct {
    logic [4:0] ori;
    logic       nm;
    int         done_cyc;
    int         busy_n;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int cyc      = 0;
  int n_vec    = 0;
  int n_bad    = 0;
  int n_done   = 0;
  int busy_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ROM: nearest-integer fixed-point trig with 8 fractional bits.
  function automatic int trig_ref(input int idx, input bit c);
    real a;
    real v;
    a = real'(idx) * 15.0 * 3.14159265358979 / 180.0;
    v = c ? $cos(a) * 256.0 : $sin(a) * 256.0;
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int ref_orient(input logic [11:0] wo, input logic [11:0] wf);
    int to, tf, ro, rf, dx, dy, best;
    longint dot, bd;
    to = int'(wo[11:8]) % 24;
    tf = int'(wf[11:8]) % 24;
    ro = int'(wo[7:0]);
    rf = int'(wf[7:0]);
    dx = rf * trig_ref(tf, 1'b1) - ro * trig_ref(to, 1'b1);
    dy = rf * trig_ref(tf, 1'b0) - ro * trig_ref(to, 1'b0);
    best = 0;
    bd   = 0;
    for (int i = 0; i < 24; i++) begin
      dot = longint'(dx) * trig_ref(i, 1'b1) + longint'(dy) * trig_ref(i, 1'b0);
      if (i == 0 || dot > bd) begin
        bd   = dot;
        best = i;
      end
    end
    return best;
  endfunction

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk({mon_e.name, "_orientation"}, int'(orientation), int'(mon_e.ori));
          chk({mon_e.name, "_no_move"}, int'(no_move), int'(mon_e.nm));
          chk({mon_e.name, "_done_cycle"}, cyc, mon_e.done_cyc);
          chk({mon_e.name, "_busy_cycles"}, busy_cnt, mon_e.busy_n);
          chk({mon_e.name, "_busy_at_done"}, int'(busy), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [11:0] wo, input logic [11:0] wf, input bit push,
                       input int ori, input bit nm, input int lat, input int bn,
                       input string name);
    exp_t e;
    @(negedge clock);
    word_o = wo;
    word_f = wf;
    enable = 1'b1;
    if (push) begin
      e.ori      = 5'(ori);
      e.nm       = nm;
      e.done_cyc = cyc + lat;
      e.busy_n   = bn;
      e.name     = name;
      exp_q.push_back(e);
    end
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic run(input logic [11:0] wo, input logic [11:0] wf, input int ori,
                     input bit nm, input int lat, input int bn, input string name);
    issue(wo, wf, 1'b1, ori, nm, lat, bn, name);
    drain(name);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_no_move"}, int'(no_move), 0);
    chk({name, "_orientation"}, int'(orientation), 0);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    //    start    final    ori nm lat busy name
    run(12'h110, 12'h115,  1, 0,  1,  0, "short_out");
    run(12'h115, 12'h110, 13, 0,  1,  0, "short_in");
    run(12'h120, 12'h120, 13, 1,  1,  0, "short_same");
    run(12'hB25, 12'h725,  3, 0, 27, 26, "move_45");
    run(12'h129, 12'h50B, 12, 0, 27, 26, "move_180");
    run(12'h50B, 12'h129,  0, 0, 27, 26, "move_0");
    run(12'h100, 12'h200,  0, 1,  3,  2, "origin_nomove");
    run(12'hF40, 12'h340,  3, 0, 27, 26, "wrap_225_45");
    run(12'h464, 12'h465,  4, 0,  1,  0, "thresh_short");
    run(12'h364, 12'h465, ref_orient(12'h364, 12'h465), 0, 27, 26, "thresh_general");

    // A second request in the middle of SEARCH must be dropped.
    d0 = n_done;
    issue(12'hB25, 12'h725, 1'b1, 3, 0, 27, 26, "mid_enable");
    repeat (10) @(negedge clock);
    word_o = 12'h110;
    word_f = 12'h115;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    drain("mid_enable");
    repeat (5) @(negedge clock);
    chk("mid_enable_done_count", n_done - d0, 1);

    // Reset in the middle of SEARCH aborts without a done pulse.
    d0 = n_done;
    issue(12'hB25, 12'h725, 1'b0, 0, 0, 0, 0, "abort");
    repeat (10) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk_zero("abort_reset");
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("abort_done_count", n_done - d0, 0);
    run(12'h129, 12'h50B, 12, 0, 27, 26, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
